// File: rtl/reg8_pkg.sv
// Shared types and sizes for the 8x8 register-file access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg8_pkg;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NREG = 8;

  // Controller modes: normal arbitration vs. hardware init sweep
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  // Meaning of the per-master wr bit
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers which master won last.
// Latency: grant is combinational from req; priority state updates at the grant edge.
// Backpressure: advance=0 suppresses all grants and freezes the priority state.
module rr_arb2 #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_q holds the index of the master granted most recently
  logic last_q, last_d;

  // Pick the requester that did not win last time when both ask
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  // Reset so that FIRST_PRIO wins the first contended cycle
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      last_q <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg8_ctrl.sv
// Shares the 8x8 register file between two masters and runs a constant-fill init sweep.
// Latency: grant and write drive are combinational; read data/rvalid arrive one cycle after grant; init takes 8 cycles.
// Backpressure: requests are held until granted; no grants while INIT runs. Optional write protection of register 0 under REG8_CTRL_PROTECT_EN.
module reg8_ctrl
  import reg8_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL   = 8'h00,
  parameter int            FIRST_PRIO = 0
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  input  logic          init_start,
  output logic          busy,
  output logic          init_done,
  output logic          wr_err,
  output logic          rf_en,
  output logic [AW-1:0] rf_wsel,
  output logic [AW-1:0] rf_rsel,
  output logic [DW-1:0] rf_d,
  input  logic [DW-1:0] rf_q
);

`ifdef REG8_CTRL_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          init_done_q, init_done_d;
  logic          wr_err_q, wr_err_d;

  logic [1:0]    arb_gnt;
  logic          arb_adv;
  op_e           op;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;

  // init_start takes the cycle away from the masters
  assign arb_adv = (state_q == ST_IDLE) && !init_start;

  rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_arb (
    .clk    (clk),
    .clr_n  (clr_n),
    .req    ({req1, req0}),
    .advance(arb_adv),
    .gnt    (arb_gnt)
  );

  // Route the granted master's operation onto a single op bus
  always_comb begin
    op       = arb_gnt[1] ? op_e'(wr1) : op_e'(wr0);
    op_addr  = arb_gnt[1] ? addr1 : addr0;
    op_wdata = arb_gnt[1] ? wdata1 : wdata0;
  end

  // Next-state, register-file drive and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_en       = 1'b0;
    rf_wsel     = '0;
    rf_d        = '0;
    rf_rsel     = '0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    init_done_d = 1'b0;
    wr_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (|arb_gnt) begin
          if (op == OP_WR) begin
            // A protected write is still consumed, just never reaches the file
            if (PROTECT && (op_addr == '0)) begin
              wr_err_d = 1'b1;
            end else begin
              rf_en   = 1'b1;
              rf_wsel = op_addr;
              rf_d    = op_wdata;
            end
          end else begin
            rf_rsel = op_addr;
            if (arb_gnt[0]) begin
              rvalid0_d = 1'b1;
              rdata0_d  = rf_q;
            end else begin
              rvalid1_d = 1'b1;
              rdata1_d  = rf_q;
            end
          end
        end
      end
      ST_INIT: begin
        rf_en   = 1'b1;
        rf_wsel = cnt_q;
        rf_d    = INIT_VAL;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any init in progress
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      init_done_q <= init_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign gnt0      = arb_gnt[0];
  assign gnt1      = arb_gnt[1];
  assign busy      = (state_q == ST_INIT);
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign init_done = init_done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg8_ctrl.sv
// Bench for reg8_ctrl with a behavioural register file attached.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 3 units later.
// Backpressure: bench holds each master request until the expected grant.
module tb_reg8_ctrl;

  localparam logic [7:0] IVAL = 8'h3C;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef REG8_CTRL_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic       req0, req1, wr0, wr1, init_start;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, init_done, wr_err, rf_en;
  logic [7:0] rdata0, rdata1, rf_d, rf_q;
  logic [2:0] rf_wsel, rf_rsel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg8_ctrl #(.INIT_VAL(IVAL), .FIRST_PRIO(0)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .init_start(init_start),
    .busy(busy), .init_done(init_done), .wr_err(wr_err),
    .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_rsel(rf_rsel), .rf_d(rf_d), .rf_q(rf_q)
  );

  // Register file attached to the controller
  logic [7:0] rf_mem [8];
  always @(posedge clk) if (rf_en) rf_mem[rf_wsel] <= rf_d;
  assign rf_q = rf_mem[rf_rsel];

  typedef struct {
    logic r0, r1, w0, w1;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1;
    logic g0, g1, en;
    logic [2:0] ws, rs;
    logic [7:0] rd;
    logic v0, v1;
    logic [7:0] q0, q1;
    logic err;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0; init_start = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    clr_n = 1'b1;
  endtask

  // Master 0 writes every register; last request is left for the caller to retire
  task automatic fill(input logic [7:0] base, input bit inc);
    for (int i = 0; i < 8; i++) begin
      step();
      req0 = 1'b1; wr0 = 1'b1; addr0 = 3'(i); wdata0 = inc ? base + 8'(i) : base;
      req1 = 1'b0; init_start = 1'b0;
      #3;
      chk($sformatf("fill_gnt0_%0d", i), gnt0, 1);
    end
  endtask

  // Random-phase model state
  logic [7:0] mem [8];
  logic       p0, p1, pw0, pw1, last, win0, win1, ww, prot, got;
  logic [2:0] pa0, pa1, wa;
  logic [7:0] pd0, pd1, wd, eq0, eq1;
  logic       ev0, ev1, eerr;

  initial begin
    //                r0 r1 w0 w1 a0    a1    d0     d1     g0 g1 en   ws    rs    rd                  v0 v1 q0     q1                  err
    tbl[0]  = '{H, H, L, L, 3'd1, 3'd2, 8'h00, 8'h00, H, L, L,   3'd0, 3'd1, 8'h00,              L, L, 8'h00, 8'h00,              L};
    tbl[1]  = '{H, H, L, L, 3'd1, 3'd2, 8'h00, 8'h00, L, H, L,   3'd0, 3'd2, 8'h00,              H, L, 8'h11, 8'h00,              L};
    tbl[2]  = '{H, H, L, L, 3'd1, 3'd2, 8'h00, 8'h00, H, L, L,   3'd0, 3'd1, 8'h00,              L, H, 8'h11, 8'h12,              L};
    tbl[3]  = '{H, H, L, L, 3'd1, 3'd2, 8'h00, 8'h00, L, H, L,   3'd0, 3'd2, 8'h00,              H, L, 8'h11, 8'h12,              L};
    tbl[4]  = '{H, L, H, L, 3'd3, 3'd0, 8'hA5, 8'h00, H, L, H,   3'd3, 3'd0, 8'hA5,              L, H, 8'h11, 8'h12,              L};
    tbl[5]  = '{H, L, L, L, 3'd3, 3'd0, 8'h00, 8'h00, H, L, L,   3'd0, 3'd3, 8'h00,              L, L, 8'h11, 8'h12,              L};
    tbl[6]  = '{L, L, L, L, 3'd0, 3'd0, 8'h00, 8'h00, L, L, L,   3'd0, 3'd0, 8'h00,              H, L, 8'hA5, 8'h12,              L};
    tbl[7]  = '{L, H, L, H, 3'd0, 3'd0, 8'h00, 8'h77, L, H, ~PROT, 3'd0, 3'd0, PROT ? 8'h00 : 8'h77, L, L, 8'hA5, 8'h12,            L};
    tbl[8]  = '{L, H, L, L, 3'd0, 3'd0, 8'h00, 8'h00, L, H, L,   3'd0, 3'd0, 8'h00,              L, L, 8'hA5, 8'h12,              PROT};
    tbl[9]  = '{L, L, L, L, 3'd0, 3'd0, 8'h00, 8'h00, L, L, L,   3'd0, 3'd0, 8'h00,              L, H, 8'hA5, PROT ? 8'h10 : 8'h77, L};
    tbl[10] = '{H, H, H, H, 3'd6, 3'd7, 8'h66, 8'h99, H, L, H,   3'd6, 3'd0, 8'h66,              L, L, 8'hA5, PROT ? 8'h10 : 8'h77, L};
    tbl[11] = '{L, H, L, H, 3'd6, 3'd7, 8'h66, 8'h99, L, H, H,   3'd7, 3'd0, 8'h99,              L, L, 8'hA5, PROT ? 8'h10 : 8'h77, L};

    // Preload registers with 8'h10+i, then start clean
    do_reset();
    fill(8'h10, 1'b1);
    do_reset();
    #3;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_err", wr_err, 0);

    // Directed vectors: arbitration, write/read, protection
    for (int i = 0; i < 12; i++) begin
      step();
      req0 = tbl[i].r0; req1 = tbl[i].r1; wr0 = tbl[i].w0; wr1 = tbl[i].w1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata0 = tbl[i].d0; wdata1 = tbl[i].d1;
      #3;
      chk($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("v%0d_rf_en", i), rf_en, tbl[i].en);
      chk($sformatf("v%0d_rf_wsel", i), rf_wsel, tbl[i].ws);
      chk($sformatf("v%0d_rf_rsel", i), rf_rsel, tbl[i].rs);
      chk($sformatf("v%0d_rf_d", i), rf_d, tbl[i].rd);
      chk($sformatf("v%0d_rvalid0", i), rvalid0, tbl[i].v0);
      chk($sformatf("v%0d_rvalid1", i), rvalid1, tbl[i].v1);
      chk($sformatf("v%0d_rdata0", i), rdata0, tbl[i].q0);
      chk($sformatf("v%0d_rdata1", i), rdata1, tbl[i].q1);
      chk($sformatf("v%0d_wr_err", i), wr_err, tbl[i].err);
    end

    // Full init sweep over 8'hFF contents, master 0 waiting throughout
    fill(8'hFF, 1'b0);
    step();
    init_start = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd5;
    #3;
    chk("init_start_gnt0", gnt0, 0);
    chk("init_start_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      init_start = (k == 3);
      #3;
      chk($sformatf("init%0d_busy", k), busy, 1);
      chk($sformatf("init%0d_gnt0", k), gnt0, 0);
      chk($sformatf("init%0d_rf_en", k), rf_en, 1);
      chk($sformatf("init%0d_rf_wsel", k), rf_wsel, k);
      chk($sformatf("init%0d_rf_d", k), rf_d, IVAL);
      chk($sformatf("init%0d_done", k), init_done, 0);
    end
    step();
    init_start = 1'b0;
    #3;
    chk("init_end_busy", busy, 0);
    chk("init_end_done", init_done, 1);
    chk("init_end_gnt0", gnt0, 1);
    chk("init_end_rsel", rf_rsel, 5);
    step();
    req0 = 1'b0;
    #3;
    chk("init_after_rvalid0", rvalid0, 1);
    chk("init_after_rdata0", rdata0, IVAL);
    chk("init_after_done", init_done, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      req0 = 1'b1; wr0 = 1'b0; addr0 = 3'(i);
      #3;
      chk($sformatf("init_rd%0d_gnt0", i), gnt0, 1);
      step();
      req0 = 1'b0;
      #3;
      chk($sformatf("init_rd%0d_rvalid0", i), rvalid0, 1);
      chk($sformatf("init_rd%0d_rdata0", i), rdata0, IVAL);
    end

    // Reset in the middle of an init sweep
    fill(8'hFF, 1'b0);
    step();
    req0 = 1'b0; init_start = 1'b1;
    #3;
    chk("abort_start_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      init_start = 1'b0;
      #3;
      chk($sformatf("abort_cnt%0d", k), rf_wsel, k);
    end
    step();
    clr_n = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd5;
    #3;
    chk("abort_rst_busy", busy, 1);
    chk("abort_rst_gnt0", gnt0, 0);
    step();
    clr_n = 1'b1;
    #3;
    chk("abort_busy", busy, 0);
    chk("abort_rvalid0", rvalid0, 0);
    chk("abort_rvalid1", rvalid1, 0);
    chk("abort_done0", init_done, 0);
    chk("abort_gnt0_first", gnt0, 1);
    chk("abort_gnt1_first", gnt1, 0);
    step();
    req0 = 1'b0;
    #3;
    chk("abort_gnt1_second", gnt1, 1);
    chk("abort_done1", init_done, 0);
    chk("abort_rvalid0_b", rvalid0, 1);
    chk("abort_rdata0_reg0", rdata0, IVAL);
    step();
    req1 = 1'b0;
    #3;
    chk("abort_rvalid1_b", rvalid1, 1);
    chk("abort_rdata1_reg5", rdata1, 8'hFF);
    chk("abort_done2", init_done, 0);
    step();
    #3;
    chk("abort_done3", init_done, 0);

    // Randomised traffic against a behavioural model
    do_reset();
    step();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #3;
      if (init_done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("rand_init_done_wait", got, 1);
    for (int i = 0; i < 8; i++) mem[i] = IVAL;
    last = 1'b1;
    p0 = 1'b0; p1 = 1'b0;
    ev0 = 1'b0; ev1 = 1'b0; eq0 = 8'h00; eq1 = 8'h00; eerr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1'b1; pw0 = 1'($urandom_range(0, 1)); pa0 = 3'($urandom_range(0, 7)); pd0 = 8'($urandom);
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1'b1; pw1 = 1'($urandom_range(0, 1)); pa1 = 3'($urandom_range(0, 7)); pd1 = 8'($urandom);
      end
      req0 = p0; wr0 = pw0; addr0 = pa0; wdata0 = pd0;
      req1 = p1; wr1 = pw1; addr1 = pa1; wdata1 = pd1;
      #3;
      win0 = p0 && (!p1 || last);
      win1 = p1 && !win0;
      chk("rnd_gnt0", gnt0, win0);
      chk("rnd_gnt1", gnt1, win1);
      chk("rnd_rvalid0", rvalid0, ev0);
      chk("rnd_rvalid1", rvalid1, ev1);
      chk("rnd_rdata0", rdata0, eq0);
      chk("rnd_rdata1", rdata1, eq1);
      chk("rnd_wr_err", wr_err, eerr);
      ev0 = 1'b0; ev1 = 1'b0; eerr = 1'b0;
      if (win0 || win1) begin
        ww = win0 ? pw0 : pw1;
        wa = win0 ? pa0 : pa1;
        wd = win0 ? pd0 : pd1;
        if (ww) begin
          prot = PROT && (wa == 3'd0);
          chk("rnd_rf_en", rf_en, !prot);
          if (!prot) begin
            chk("rnd_rf_wsel", rf_wsel, wa);
            chk("rnd_rf_d", rf_d, wd);
            mem[wa] = wd;
          end
          eerr = prot;
        end else begin
          chk("rnd_rf_rsel", rf_rsel, wa);
          chk("rnd_rd_en", rf_en, 0);
          if (win0) begin ev0 = 1'b1; eq0 = mem[wa]; end
          else begin ev1 = 1'b1; eq1 = mem[wa]; end
        end
        last = win1;
        if (win0) p0 = 1'b0; else p1 = 1'b0;
      end else begin
        chk("rnd_idle_en", rf_en, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg8_ctrl.md
Name: reg8_ctrl

Overview:
- Access controller that sits in front of the 8x8 register file (single write port, single combinational read port).
- Shares both ports between two requesters (masters 0/1) using round-robin arbitration.
- Provides a hardware init sequencer that writes a constant to all 8 registers.
- Drives the register file's en/wsel/rsel/d pins and returns registered read data to the granted master.

Parameters:
- INIT_VAL, 8'h00, value written to every register by the init sequence.
- FIRST_PRIO, 0, master that wins the first contended cycle after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr_n  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  master request; held until granted.
- wr0 / wr1  in  1  1 = write, 0 = read; valid with req.
- addr0 / addr1  in  3  register index.
- wdata0 / wdata1  in  8  write data.
- gnt0 / gnt1  out  1  combinational accept strobe; the request is consumed at this clock edge.
- rvalid0 / rvalid1  out  1  registered; read data valid for that master.
- rdata0 / rdata1  out  8  registered read data.
- init_start  in  1  single-cycle pulse that starts the init sequence.
- busy  out  1  high while in INIT.
- init_done  out  1  registered single-cycle pulse at the end of init.
- wr_err  out  1  registered; write dropped by protection (optional feature only).
- rf_en  out  1  to register file en.
- rf_wsel  out  3  to register file wsel.
- rf_rsel  out  3  to register file rsel.
- rf_d  out  8  to register file d.
- rf_q  in  8  from register file q.

Behaviour:
- Reset (clr_n=0 at a rising edge):
  - state=IDLE, cnt=0, last grant = !FIRST_PRIO.
  - rvalid0/1=0, rdata0/1=0, init_done=0, wr_err=0.
  - Reset mid-INIT aborts the sequence; registers already written are left unchanged.
- States: IDLE and INIT.
  - IDLE with init_start=1 -> INIT, cnt=0. In that cycle init_start has priority and no grant is issued.
  - INIT: busy=1, gnt0=gnt1=0, rf_en=1, rf_wsel=cnt, rf_d=INIT_VAL, cnt increments by 1.
  - When cnt==7: -> IDLE and init_done=1 in the following cycle.
  - init_start during INIT is ignored.
  - Init takes 8 cycles total; busy falls in the cycle init_done rises.
- Arbitration (IDLE only):
  - One request asserted: that master is granted.
  - Both asserted: the master not granted last time wins; the last-grant register updates on every grant.
  - At most one gnt per cycle. A losing request stays pending and wins the next cycle.
- Grant cycle N, write:
  - rf_en=1, rf_wsel=addr, rf_d=wdata (combinational); register file updates at the end of N.
- Grant cycle N, read:
  - rf_rsel=addr. rf_q is sampled into rdata of the granted master at the end of N; rvalid=1 for cycle N+1 only.
  - rdata holds its value until the next read for that master.
- Default drive when no write or init: rf_en=0, rf_wsel=0, rf_d=0.
- Default drive when no read grant: rf_rsel=0.
- Read-after-write to the same address in consecutive grants returns the new data.
- Read in cycle N of an address written in the same cycle cannot occur (one op per cycle).

Optional Feature:
- Macro: REG8_CTRL_PROTECT_EN.
- Defined:
  - Register 0 is write-protected for masters. The write is still granted, but rf_en=0.
  - wr_err pulses 1 in cycle N+1.
  - The init sequence still writes register 0.
- Undefined:
  - All writes are performed; wr_err is tied 0.

Decomposition:
- reg8_pkg:
  - AW=3, DW=8, NREG=8.
  - state enum {ST_IDLE, ST_INIT}.
  - op encoding (wr bit meaning).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Ports: clk, clr_n, req[1:0], advance, gnt[1:0].
  - Holds the last-grant register; advance is driven low during INIT.

Test Plan:
- Reset, then master 0 writes 8'hA5 to addr 3 -> gnt0 same cycle, rf_en=1, rf_wsel=3; master 0 reads addr 3 next -> rvalid0 one cycle after gnt0, rdata0=8'hA5.
- req0 and req1 held high for 4 cycles, both reads -> grants alternate 0,1,0,1 (FIRST_PRIO=0); each rvalid lags its gnt by 1 cycle.
- Fill all regs with 8'hFF, init_start with INIT_VAL=8'h3C -> busy for 8 cycles with rf_wsel 0..7, then init_done one cycle; read each addr -> 8'h3C; req0 asserted during init gets no grant until busy=0.
- clr_n low at init cycle 4 -> busy=0, init_done never pulses, rvalid0/1=0 next cycle, arbitration restarts from FIRST_PRIO.
- REG8_CTRL_PROTECT_EN defined, master 1 writes 8'h77 to addr 0 -> gnt1=1, rf_en=0, wr_err=1 next cycle, read addr 0 unchanged; undefined -> read returns 8'h77, wr_err stays 0.
